wb_gpio_bank: RTL and testbench
===============================

# wb_gpio_bank

Parametrised Wishbone-slave GPIO bank giving the core register-level control of a configurable number of user I/O pins, replacing the fixed pin-slice passthrough in the user project wrapper. It drives `io_out`/`io_oeb` from software-writable registers, synchronises `io_in`, and raises a level interrupt on per-pin programmable edges. It sits between the Caravel Wishbone bus and the chosen pad slice; the wrapper performs the address-window decode.

## Interface
- `N_PINS`, 16: number of GPIO pins, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `wb_clk_i` in 1: sole clock; all state on rising edge.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `wbs_cyc_i` in 1: Wishbone cycle.
- `wbs_stb_i` in 1: Wishbone strobe.
- `wbs_we_i` in 1: write enable.
- `wbs_sel_i` in 4: byte-lane selects.
- `wbs_adr_i` in 32: byte address; only bits [4:2] decoded.
- `wbs_dat_i` in 32: write data.
- `wbs_dat_o` out 32: read data.
- `wbs_ack_o` out 1: transfer acknowledge.
- `io_in` in N_PINS: pad inputs.
- `io_out` out N_PINS: pad outputs.
- `io_oeb` out N_PINS: pad output enables, active low.
- `irq` out 1: level interrupt to `user_irq`.

## Operation
- Register map (word offset via adr[4:2]): 0x00 OUT (RW), 0x04 OEB (RW), 0x08 IN (RO), 0x0C IRQ_EN (RW), 0x10 EDGE (RW; 1=rising, 0=falling), 0x14 STATUS (read; write-1-to-clear). 0x18/0x1C: read 0, writes ignored, still acked.
- Bits [31:N_PINS] of every register read 0; writes to them ignored.
- Writes honour `wbs_sel_i` per byte lane; unselected bytes unchanged. STATUS clear also byte-masked.
- Writes to IN are ignored and acked.
- `io_out` = OUT, `io_oeb` = OEB, both directly from registers.
- Input path: `io_in` -> SYNC_STAGES flops -> IN register value (last stage). One extra flop `prev` holds the previous synced value for edge detect.
- Edge event on pin i: rising = synced & ~prev with EDGE[i]=1; falling = ~synced & prev with EDGE[i]=0. Events set STATUS[i] regardless of IRQ_EN[i].
- `irq` registered: `irq` <= |(STATUS & IRQ_EN).
- Reset values: OUT=0, OEB=all ones (all inputs), IRQ_EN=0, EDGE=all ones, STATUS=0, synchronisers and `prev`=0, `wbs_ack_o`=0, `wbs_dat_o`=0, `irq`=0.

## Timing
- Wishbone classic: ack asserted the cycle after `cyc & stb` sampled with ack low; held exactly one cycle; no new ack in the cycle following an ack (max one transfer per 2 cycles).
- Write data committed on the same edge that asserts ack; read data valid in `wbs_dat_o` while ack is high, 0 otherwise.
- Master dropping `stb` before ack: ack still issues next cycle, write still commits (master must not abort).
- Pin change -> IN visible: SYNC_STAGES cycles. Pin edge -> STATUS set: SYNC_STAGES+1 cycles; -> `irq` high: SYNC_STAGES+2 cycles.
- Simultaneous edge event and W1C of same bit: set wins, STATUS stays 1.
- Writing IRQ_EN or clearing STATUS: `irq` follows one cycle after commit.
- Reset asserted mid-transfer: ack and all registers clear immediately (async); no ack for the aborted transfer.

## Configuration
- `GPIO_IRQ_EN` defined: edge detect, IRQ_EN, EDGE, STATUS and `irq` implemented as above.
- Not defined: `prev`, IRQ_EN, EDGE, STATUS logic removed; offsets 0x0C–0x14 read 0, writes ignored but acked; `irq` tied 0. OUT/OEB/IN unchanged.

## Test plan
- Reset, then read all six offsets -> OUT 0x0, OEB 0x0000FFFF, IN 0x0, IRQ_EN 0x0, EDGE 0x0000FFFF, STATUS 0x0; `io_oeb`=0xFFFF.
- Write OUT=0xFFFFFFFF with sel=4'b0001 -> `io_out`=0x00FF, readback 0x000000FF; ack exactly 1 cycle after stb, low the next.
- Drive `io_in`[3] 0->1 with EDGE=all ones, IRQ_EN=0x8 -> IN[3] after 2 cycles, STATUS=0x8 after 3, `irq`=1 after 4.
- Write STATUS=0x8 in same cycle as new rising edge committing on pin 3 -> STATUS stays 0x8, `irq` stays 1; later clear alone -> `irq` 0 one cycle after ack.
- EDGE[5]=0, `io_in`[5] 0->1->0 -> STATUS=0x20 only after fall; IRQ_EN=0 keeps `irq`=0 while STATUS latches.
- Assert `wb_rst_i` during a write with ack pending -> ack never asserted, target register at reset value; build without `GPIO_IRQ_EN` -> offset 0x14 reads 0, `irq` constant 0.

Source files
------------

// File: rtl/wb_gpio_bank_if.sv
// Wishbone classic bus bundle for wb_gpio_bank.
// Signal names keep the Caravel wbs_* naming, seen from the slave side.
// The master modport drives the request; the slave modport returns data and ack.
interface wb_gpio_bank_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank: Wishbone-slave GPIO bank.
// OUT/OEB registers drive the pads directly; io_in is synchronised and
// readable as IN. With the GPIO_IRQ_EN macro defined, per-pin edge
// detection sets sticky STATUS bits (W1C) and raises a level irq when
// STATUS & IRQ_EN is non-zero; without it that block is absent and irq is 0.
// Word map on adr[4:2]: 0 OUT, 1 OEB, 2 IN, 3 IRQ_EN, 4 EDGE, 5 STATUS.
module wb_gpio_bank #(
    parameter int N_PINS      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_gpio_bank_if.slave     bus,
    input  logic [N_PINS-1:0] io_in,
    output logic [N_PINS-1:0] io_out,
    output logic [N_PINS-1:0] io_oeb,
    output logic              irq
);

    localparam logic [2:0] W_OUT    = 3'd0;
    localparam logic [2:0] W_OEB    = 3'd1;
    localparam logic [2:0] W_IN     = 3'd2;
    localparam logic [2:0] W_IRQ_EN = 3'd3;
    localparam logic [2:0] W_EDGE   = 3'd4;
    localparam logic [2:0] W_STATUS = 3'd5;

    logic              ack_reg;
    logic [31:0]       dat_o_reg;
    logic              access;
    logic              wr_en;
    logic [2:0]        word;
    logic [31:0]       byte_mask;
    logic [N_PINS-1:0] wmask;
    logic [N_PINS-1:0] wdata;
    logic [31:0]       rd_data;
    logic [N_PINS-1:0] out_reg;
    logic [N_PINS-1:0] oeb_reg;
    logic [N_PINS-1:0] sync_reg [SYNC_STAGES];
    logic [N_PINS-1:0] in_val;

    // A new transfer is accepted only while ack is low, so back-to-back
    // strobes get at most one ack every two cycles. Accepted writes commit
    // on the same edge that raises ack.
    assign access = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_reg;
    assign wr_en  = access & bus.wbs_we_i;
    assign word   = bus.wbs_adr_i[4:2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_mask[gi*8 +: 8] = {8{bus.wbs_sel_i[gi]}};
    end

    assign wmask = byte_mask[N_PINS-1:0];
    assign wdata = bus.wbs_dat_i[N_PINS-1:0];

    // Bits outside N_PINS and the undecoded address bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.wbs_adr_i, bus.wbs_dat_i, byte_mask};

    function automatic logic [N_PINS-1:0] merge(input logic [N_PINS-1:0] old_val);
        return (old_val & ~wmask) | (wdata & wmask);
    endfunction

    // Input synchroniser chain; the last stage is the IN register value.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            // First stage samples the raw pads.
            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i) sync_reg[gi] <= '0;
                else          sync_reg[gi] <= io_in;
            end
        end else begin : g_rest
            // Later stages shift the value along the chain.
            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i) sync_reg[gi] <= '0;
                else          sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    assign in_val = sync_reg[SYNC_STAGES-1];

    // Pad control registers with byte-lane write masking.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_reg <= '0;
            oeb_reg <= '1;
        end else if (wr_en) begin
            if (word == W_OUT) out_reg <= merge(out_reg);
            if (word == W_OEB) oeb_reg <= merge(oeb_reg);
        end
    end

    assign io_out = out_reg;
    assign io_oeb = oeb_reg;

`ifdef GPIO_IRQ_EN
    logic [N_PINS-1:0] prev_reg;
    logic [N_PINS-1:0] irq_en_reg;
    logic [N_PINS-1:0] edge_reg;
    logic [N_PINS-1:0] status_reg;
    logic              irq_reg;
    logic [N_PINS-1:0] edge_event;
    logic [N_PINS-1:0] status_clr;

    // EDGE=1 selects rising edges, EDGE=0 falling edges, per pin.
    assign edge_event = ( edge_reg &  in_val & ~prev_reg)
                      | (~edge_reg & ~in_val &  prev_reg);

    assign status_clr = (wr_en && word == W_STATUS) ? (wdata & wmask) : '0;

    // Edge history, interrupt configuration and sticky status; a new event
    // wins over a simultaneous W1C of the same bit.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            prev_reg   <= '0;
            irq_en_reg <= '0;
            edge_reg   <= '1;
            status_reg <= '0;
        end else begin
            prev_reg   <= in_val;
            status_reg <= (status_reg & ~status_clr) | edge_event;
            if (wr_en && word == W_IRQ_EN) irq_en_reg <= merge(irq_en_reg);
            if (wr_en && word == W_EDGE)   edge_reg   <= merge(edge_reg);
        end
    end

    // Registered level interrupt.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) irq_reg <= 1'b0;
        else          irq_reg <= |(status_reg & irq_en_reg);
    end

    assign irq = irq_reg;

    // Read-data multiplexer, zero-extended to the bus width.
    always_comb begin
        rd_data = '0;
        case (word)
            W_OUT:    rd_data[N_PINS-1:0] = out_reg;
            W_OEB:    rd_data[N_PINS-1:0] = oeb_reg;
            W_IN:     rd_data[N_PINS-1:0] = in_val;
            W_IRQ_EN: rd_data[N_PINS-1:0] = irq_en_reg;
            W_EDGE:   rd_data[N_PINS-1:0] = edge_reg;
            W_STATUS: rd_data[N_PINS-1:0] = status_reg;
            default:  rd_data = '0;
        endcase
    end
`else
    assign irq = 1'b0;

    // Read-data multiplexer; interrupt offsets read as zero in this build.
    always_comb begin
        rd_data = '0;
        case (word)
            W_OUT:   rd_data[N_PINS-1:0] = out_reg;
            W_OEB:   rd_data[N_PINS-1:0] = oeb_reg;
            W_IN:    rd_data[N_PINS-1:0] = in_val;
            default: rd_data = '0;
        endcase
    end
`endif

    // Bus response: one-cycle ack; read data present only during a read ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_reg   <= 1'b0;
            dat_o_reg <= '0;
        end else begin
            ack_reg   <= access;
            dat_o_reg <= (access && !bus.wbs_we_i) ? rd_data : '0;
        end
    end

    assign bus.wbs_ack_o = ack_reg;
    assign bus.wbs_dat_o = dat_o_reg;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Directed bench for wb_gpio_bank (N_PINS=16, SYNC_STAGES=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Interrupt checks follow whether GPIO_IRQ_EN is defined for this build.
module tb_wb_gpio_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] io_in = '0;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic        irq;

    int n_asserts = 0;
    int n_fail    = 0;

    logic ack_prev_reg = 1'b0;

    wb_gpio_bank_if wb ();

    wb_gpio_bank #(.N_PINS(16), .SYNC_STAGES(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (wb.slave),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Bus protocol monitor: no back-to-back acks, data idle at zero.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            n_asserts++;
            if (ack_prev_reg === 1'b1 && wb.wbs_ack_o === 1'b1) begin
                n_fail++;
                $error("FAIL mon_ack_b2b: observed %0h required %0h", wb.wbs_ack_o, 1'b0);
            end
            n_asserts++;
            if (wb.wbs_ack_o === 1'b0 && wb.wbs_dat_o !== 32'h0) begin
                n_fail++;
                $error("FAIL mon_dat_idle: observed %0h required %0h", wb.wbs_dat_o, 32'h0);
            end
        end
        ack_prev_reg <= wb.wbs_ack_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single write; returns 1 unit after the edge following the ack.
    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic irq_at_ack);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        tick();
        check("wr_ack_high", wb.wbs_ack_o, 1'b1);
        irq_at_ack   = irq;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        tick();
        check("wr_ack_low", wb.wbs_ack_o, 1'b0);
        $display("write adr=%02h dat=%08h sel=%b", adr[7:0], dat, sel);
    endtask

    // Single read; data is captured while ack is high.
    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = adr;
        wb.wbs_sel_i = 4'hF;
        tick();
        check("rd_ack_high", wb.wbs_ack_o, 1'b1);
        dat          = wb.wbs_dat_o;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        tick();
        check("rd_ack_low", wb.wbs_ack_o, 1'b0);
        check("rd_dat_idle", wb.wbs_dat_o, 32'h0);
        $display("read  adr=%02h dat=%08h", adr[7:0], dat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ia;

        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Reset state of every register and pad output.
        check("rst_io_oeb", io_oeb, 16'hFFFF);
        check("rst_io_out", io_out, 16'h0000);
        check("rst_irq", irq, 1'b0);
        wb_read(32'h00, rd); check("rst_out", rd, 32'h0);
        wb_read(32'h04, rd); check("rst_oeb", rd, 32'h0000FFFF);
        wb_read(32'h08, rd); check("rst_in", rd, 32'h0);
        wb_read(32'h0C, rd); check("rst_irq_en", rd, 32'h0);
`ifdef GPIO_IRQ_EN
        wb_read(32'h10, rd); check("rst_edge", rd, 32'h0000FFFF);
`else
        wb_read(32'h10, rd); check("rst_edge_absent", rd, 32'h0);
`endif
        wb_read(32'h14, rd); check("rst_status", rd, 32'h0);

        // Byte-lane masking on OUT and OEB; IN and unused offsets.
        wb_write(32'h00, 32'hFFFFFFFF, 4'b0001, ia);
        check("out_sel0_pad", io_out, 16'h00FF);
        wb_read(32'h00, rd); check("out_sel0_rd", rd, 32'h000000FF);
        wb_write(32'h04, 32'h0000A5C3, 4'b0010, ia);
        check("oeb_sel1_pad", io_oeb, 16'hA5FF);
        wb_write(32'h00, 32'hFFFF1234, 4'b1111, ia);
        check("out_full_pad", io_out, 16'h1234);
        wb_write(32'h08, 32'h0000FFFF, 4'b1111, ia);
        wb_read(32'h08, rd); check("in_wr_ignored", rd, 32'h0);
        wb_write(32'h18, 32'hFFFFFFFF, 4'b1111, ia);
        wb_read(32'h18, rd); check("off18_zero", rd, 32'h0);
        wb_read(32'h1C, rd); check("off1c_zero", rd, 32'h0);

`ifdef GPIO_IRQ_EN
        // Rising edge on pin 3: STATUS at +3 edges, irq at +4.
        wb_write(32'h0C, 32'h00000008, 4'b1111, ia);
        io_in[3] = 1'b1;
        tick(); check("edge3_irq_c1", irq, 1'b0);
        tick(); check("edge3_irq_c2", irq, 1'b0);
        tick(); check("edge3_irq_c3", irq, 1'b0);
        tick(); check("edge3_irq_c4", irq, 1'b1);
        wb_read(32'h08, rd); check("edge3_in", rd, 32'h00000008);
        wb_read(32'h14, rd); check("edge3_status", rd, 32'h00000008);

        // W1C in the same edge as a fresh rising event: set wins.
        io_in[3] = 1'b0;
        repeat (5) tick();
        io_in[3] = 1'b1;
        tick();
        tick();
        wb_write(32'h14, 32'h00000008, 4'b1111, ia);
        check("w1c_race_irq", irq, 1'b1);
        wb_read(32'h14, rd); check("w1c_race_status", rd, 32'h00000008);

        // Plain clear: irq drops one cycle after the ack.
        wb_write(32'h14, 32'h00000008, 4'b1111, ia);
        check("clr_irq_at_ack", ia, 1'b1);
        check("clr_irq_after", irq, 1'b0);
        wb_read(32'h14, rd); check("clr_status", rd, 32'h0);

        // Falling-edge mode on pin 5 with its interrupt masked.
        wb_write(32'h0C, 32'h00000000, 4'b1111, ia);
        wb_write(32'h10, 32'h0000FFDF, 4'b1111, ia);
        io_in[5] = 1'b1;
        repeat (5) tick();
        wb_read(32'h14, rd); check("fall5_after_rise", rd, 32'h0);
        io_in[5] = 1'b0;
        repeat (5) tick();
        wb_read(32'h14, rd); check("fall5_status", rd, 32'h00000020);
        check("fall5_irq_masked", irq, 1'b0);
`else
        // Interrupt block absent: offsets read zero, irq stays low.
        wb_write(32'h0C, 32'hFFFFFFFF, 4'b1111, ia);
        wb_read(32'h0C, rd); check("noirq_en_zero", rd, 32'h0);
        io_in[3] = 1'b1;
        repeat (5) tick();
        wb_read(32'h08, rd); check("noirq_in", rd, 32'h00000008);
        wb_read(32'h14, rd); check("noirq_status_zero", rd, 32'h0);
        check("noirq_irq", irq, 1'b0);
`endif

        // Reset arriving while a write is pending: no ack, OUT back to 0.
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_adr_i = 32'h00;
        wb.wbs_dat_i = 32'h0000BEEF;
        wb.wbs_sel_i = 4'hF;
        #2 rst = 1'b1;
        tick();
        check("rst_mid_ack", wb.wbs_ack_o, 1'b0);
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        check("rst_mid_out", io_out, 16'h0000);
        check("rst_mid_oeb", io_oeb, 16'hFFFF);
        #3 rst = 1'b0;
        tick();
        check("rst_mid_ack_after", wb.wbs_ack_o, 1'b0);
        wb_read(32'h00, rd); check("rst_mid_out_rd", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before limit");
        $fatal(1, "timeout");
    end

endmodule
